// File: rtl/lcfg_cfgo_arbiter.sv
// lcfg_cfgo_arbiter: round-robin arbiter funnelling four requesters onto one config bus
// with a bounded wait for target completion and a timeout error value.
module lcfg_cfgo_arbiter #(
  parameter int timeout_cycles = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   req_irdy,
  input  logic [3:0]   req_write,
  input  logic [63:0]  req_addr,
  input  logic [127:0] req_wr_data,
  output logic [3:0]   req_trdy,
  output logic [31:0]  req_rd_data,
  output logic         cfgo_irdy,
  input  logic         cfgo_trdy,
  output logic [15:0]  cfgo_addr,
  output logic         cfgo_write,
  output logic [31:0]  cfgo_wr_data,
  input  logic [31:0]  cfgo_rd_data,
  output logic [1:0]   grant_id,
  output logic         timeout_err
);
  typedef enum logic [2:0] {IDLE = 3'b001, BUSY = 3'b010, DONE = 3'b100} state_t;
  state_t state, state_nxt;
  logic [1:0]  last_grant, pick, idx;
  logic        found, busy, to_hit;
  logic [15:0] wait_cnt;
  logic [31:0] hold;
  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    pick = last_grant;
    found = 1'b0;
    idx = last_grant;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && req_irdy[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  assign busy   = state == BUSY;
  assign to_hit = wait_cnt == 16'(timeout_cycles - 1);
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = found ? BUSY : IDLE;
      BUSY:    state_nxt = (cfgo_trdy || to_hit) ? DONE : BUSY;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_id    <= 2'd0;
      last_grant  <= 2'd3;
      hold        <= 32'h0;
      wait_cnt    <= 16'h0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_err <= busy && !cfgo_trdy && to_hit;
      if (state == IDLE && found) begin
        grant_id   <= pick;
        last_grant <= pick;
        wait_cnt   <= 16'h0;
      end
      // A completion in the timeout cycle wins over the error value.
      if (busy) begin
        if (cfgo_trdy) hold <= cfgo_rd_data;
        else if (to_hit) hold <= 32'hFFFF_FFFF;
        else wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end
  assign cfgo_irdy    = busy;
  assign cfgo_addr    = busy ? req_addr[{grant_id, 4'b0} +: 16] : 16'h0;
  assign cfgo_write   = busy ? req_write[grant_id] : 1'b0;
  assign cfgo_wr_data = busy ? req_wr_data[{grant_id, 5'b0} +: 32] : 32'h0;
  assign req_trdy     = (state == DONE) ? (4'b0001 << grant_id) : 4'b0000;
  assign req_rd_data  = hold;
endmodule

// File: tb/tb_lcfg_cfgo_arbiter.sv
// tb_lcfg_cfgo_arbiter: directed and randomized transactions checked against a
// transaction-level model of the arbiter (round-robin pick, latency, timeout value).
module tb_lcfg_cfgo_arbiter;
  logic         clk = 1'b0, reset_n = 1'b0;
  logic [3:0]   req_irdy = '0, req_write = '0, req_trdy;
  logic [63:0]  req_addr = '0;
  logic [127:0] req_wr_data = '0;
  logic [31:0]  req_rd_data, cfgo_wr_data, cfgo_rd_data = '0;
  logic         cfgo_irdy, cfgo_trdy = 1'b0, cfgo_write, timeout_err;
  logic [15:0]  cfgo_addr;
  logic [1:0]   grant_id;
  int n_chk = 0, n_err = 0;
  logic [3:0]  pend = '0;
  logic [1:0]  last_g = 2'd3, exp_gid = 2'd0;
  logic [31:0] prev = '0;
  lcfg_cfgo_arbiter #(.timeout_cycles(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_irdy(req_irdy), .req_write(req_write),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_trdy(req_trdy),
    .req_rd_data(req_rd_data), .cfgo_irdy(cfgo_irdy), .cfgo_trdy(cfgo_trdy),
    .cfgo_addr(cfgo_addr), .cfgo_write(cfgo_write), .cfgo_wr_data(cfgo_wr_data),
    .cfgo_rd_data(cfgo_rd_data), .grant_id(grant_id), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] rr(input logic [3:0] m, input logic [1:0] last);
    for (int i = 1; i <= 4; i++) if (m[(int'(last) + i) % 4]) return 2'((int'(last) + i) % 4);
    return last;
  endfunction
  task automatic set_slot(input int i, input logic [15:0] a, input logic w, input logic [31:0] d);
    req_addr[16*i +: 16] = a;
    req_write[i] = w;
    req_wr_data[32*i +: 32] = d;
  endtask
  task automatic do_txn(input logic [3:0] add, input int lat, input logic [31:0] rd);
    logic [1:0] g;
    logic [15:0] a;
    logic w, to;
    logic [31:0] d, exp_rd;
    check("idle_trdy", req_trdy, 0);
    check("idle_cfgo_irdy", cfgo_irdy, 0);
    check("idle_timeout", timeout_err, 0);
    check("idle_rd_hold", req_rd_data, prev);
    check("idle_write", cfgo_write, 0);
    check("idle_wr_data", cfgo_wr_data, 0);
    pend |= add;
    req_irdy = pend;
    cfgo_trdy = 1'($urandom);
    cfgo_rd_data = $urandom;
    if (pend == 0) begin
      @(negedge clk);
      check("stay_idle", cfgo_irdy, 0);
      check("idle_gid", grant_id, exp_gid);
      return;
    end
    g = rr(pend, last_g);
    a = req_addr[16*g +: 16];
    w = req_write[g];
    d = req_wr_data[32*g +: 32];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("busy_irdy", cfgo_irdy, 1);
      check("busy_gid", grant_id, g);
      check("busy_addr", cfgo_addr, a);
      check("busy_write", cfgo_write, w);
      check("busy_wr_data", cfgo_wr_data, d);
      check("busy_trdy", req_trdy, 0);
      if (k == 0 && $urandom_range(0, 3) == 0) req_irdy = 4'b0;
      cfgo_trdy = (k == lat);
      cfgo_rd_data = (k == lat) ? rd : $urandom;
      if (k == lat) break;
    end
    to = lat > 3;
    exp_rd = to ? 32'hFFFF_FFFF : rd;
    @(negedge clk);
    check("done_cfgo_irdy", cfgo_irdy, 0);
    check("done_trdy", req_trdy, 4'b0001 << g);
    check("done_rd_data", req_rd_data, exp_rd);
    check("done_timeout", timeout_err, to);
    pend[g] = 1'b0;
    req_irdy = pend;
    cfgo_trdy = 1'($urandom);
    last_g = g;
    exp_gid = g;
    prev = exp_rd;
    @(negedge clk);
  endtask
  initial begin
    #1;
    check("rst_cfgo_irdy", cfgo_irdy, 0);
    check("rst_trdy", req_trdy, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_gid", grant_id, 0);
    check("rst_rd_data", req_rd_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) set_slot(i, 16'(i * 16 + 1), 1'b0, 32'(i));
    do_txn(4'hF, 0, 32'h1111_0000);
    repeat (3) do_txn(4'h0, 0, $urandom);
    do_txn(4'hF, 0, 32'h2222_0000);
    set_slot(2, 16'h0010, 1'b0, 32'h0);
    pend = '0;
    last_g = 2'd1;
    do_txn(4'h0, 0, 32'h0);
    set_slot(0, 16'h0010, 1'b0, 32'h0);
    do_txn(4'b0001, 0, 32'hDEAD_BEEF);
    set_slot(2, 16'hA5A5, 1'b1, 32'h1234_5678);
    do_txn(4'b0100, 2, 32'h5555_AAAA);
    do_txn(4'b0001, 9, 32'h0BAD_0BAD);
    do_txn(4'b0001, 3, 32'hCAFE_F00D);
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) if (!pend[i]) set_slot(i, 16'($urandom), 1'($urandom), $urandom);
      do_txn(($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), $urandom_range(0, 5), $urandom);
    end
    req_irdy = 4'b0010;
    pend = 4'b0010;
    @(negedge clk);
    check("pre_rst_irdy", cfgo_irdy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_irdy", cfgo_irdy, 0);
    check("async_rst_trdy", req_trdy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    req_irdy = '0;
    cfgo_trdy = 1'b0;
    pend = '0;
    last_g = 2'd3;
    exp_gid = 2'd0;
    prev = '0;
    @(negedge clk);
    check("post_rst_trdy", req_trdy, 0);
    check("post_rst_irdy", cfgo_irdy, 0);
    do_txn(4'hF, 0, 32'h7777_7777);
    check("post_rst_first", last_g, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
